traffic_light_fsm: RTL and testbench
====================================

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 The block SHALL have parameter T_GREEN, default 5000, green duration in 1 ms ticks.
REQ-002 The block SHALL have parameter T_YELLOW, default 2000, yellow duration in ticks.
REQ-003 The block SHALL have parameter T_ALLRED, default 1000, all-red clearance duration in ticks.
REQ-004 The block SHALL have parameter T_WALK, default 4000, pedestrian walk duration in ticks.
REQ-005 The block SHALL have port clk_100MHz  in  1  sole clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 The block SHALL have port clk_1KHz  in  1  1 kHz square wave from the divider stage, synchronous to clk_100MHz, sampled as data.
REQ-008 The block SHALL have port ped_req  in  1  pedestrian request, already debounced, synchronous level or pulse.
REQ-009 The block SHALL have port ns_light  out  3  north-south lamps {red,yellow,green}, one-hot.
REQ-010 The block SHALL have port ew_light  out  3  east-west lamps {red,yellow,green}, one-hot.
REQ-011 The block SHALL have port walk  out  1  pedestrian walk lamp.
REQ-012 The block SHALL have port state_o  out  3  current state code, for debug.

Function
REQ-013 Tick SHALL be one clk_100MHz-cycle pulse when clk_1KHz is 1 and the 1-cycle-delayed copy is 0; no other event advances timing.
REQ-014 States SHALL be NS_GREEN, NS_YELLOW, ALLRED_1, EW_GREEN, EW_YELLOW, ALLRED_2, PED_WALK.
REQ-015 Transitions SHALL be NS_GREEN->NS_YELLOW->ALLRED_1->EW_GREEN->EW_YELLOW->ALLRED_2->NS_GREEN.
REQ-016 Exception: leaving ALLRED_1 or ALLRED_2 with ped_pending=1 SHALL go to PED_WALK; PED_WALK then exits to the green that would otherwise have followed, with a return flag recording which.
REQ-017 A 16-bit tick counter SHALL clear on every state change and increment on each tick; on the tick where it equals T_state-1 the state SHALL advance, so each state lasts exactly T_state ticks.
REQ-018 Outputs SHALL be a pure decode of the state register, changing in the same cycle as the state, with no extra latency.
REQ-019 The output decode SHALL be: GREEN states give own lamp 001, other 100; YELLOW states give own 010, other 100; ALLRED and PED_WALK give both 100; walk=1 only in PED_WALK.
REQ-020 ped_pending SHALL set on any cycle with ped_req=1 outside PED_WALK, and clear on entry to PED_WALK; ped_req in the entry cycle or during PED_WALK SHALL be discarded.
REQ-021 Conflicting greens or yellows SHALL be unreachable; an illegal state code SHALL recover to ALLRED_2 on the next cycle.
REQ-022 Parameters SHALL satisfy 1 <= T <= 65535; violation SHALL be flagged by an elaboration-time check.

Reset
REQ-023 While rst_n=0, the block SHALL hold state=ALLRED_2, counter=0, ped_pending=0, return flag=NS, ns_light=100, ew_light=100, walk=0.
REQ-024 The delayed clk_1KHz register SHALL reset to 1, so a high input at reset release produces no tick until the next genuine rising edge.
REQ-025 Reset asserted mid-state SHALL take effect immediately, asynchronously, and abandon any pending request.

Structure
REQ-026 Package traffic_pkg SHALL hold the state enum, its 3-bit encoding, and the lamp constants RED=100, YEL=010, GRN=001.
REQ-027 The rising-edge tick generator SHALL be sub-module tick_edge_detect (ports clk_100MHz, rst_n, level_in, tick_out); the rest SHALL stay flat.

Verification (T_GREEN=5, T_YELLOW=2, T_ALLRED=1, T_WALK=3; clk_1KHz from a stub toggling every 50 cycles)
REQ-028 The bench SHALL check: reset release, no ped_req -> ALLRED_2 for 1 tick, NS_GREEN 5, NS_YELLOW 2, ALLRED_1 1, EW_GREEN 5, EW_YELLOW 2, ALLRED_2 1, then repeat; lamps decoded per REQ-019.
REQ-029 The bench SHALL check: 1-cycle ped_req pulse in NS_GREEN -> NS_YELLOW 2, ALLRED_1 1, PED_WALK 3 ticks (walk=1, both 100), then EW_GREEN; ped_pending=0 afterwards.
REQ-030 The bench SHALL check: ped_req held high continuously -> PED_WALK after every ALLRED, one walk each; request during PED_WALK does not cause a back-to-back walk.
REQ-031 The bench SHALL check: clk_1KHz frozen high for 10000 cycles -> no state change; the first rising edge afterwards advances the counter by exactly 1.
REQ-032 The bench SHALL check: rst_n low at mid EW_GREEN (counter=3) -> same-cycle ns=100, ew=100, walk=0, state_o=ALLRED_2.
REQ-033 The bench SHALL check: reset released with clk_1KHz=1 -> no tick in the first cycle; ALLRED_2 lasts exactly 1 tick from the next rising edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: state encoding,
// lamp patterns and the timing-parameter range check.
package traffic_pkg;

  // Three-bit state code; 3'd7 is the only unused (illegal) code.
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_2  = 3'd5,
    PED_WALK  = 3'd6
  } state_e;

  // Lamp patterns, ordered {red, yellow, green}.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // A duration must fit the 16-bit tick counter and be at least one tick.
  function automatic bit t_ok(input int t);
    return (t >= 1) && (t <= 65535);
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Turns the 1 kHz square wave into a single-cycle tick on each rising edge.
module tick_edge_detect (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic level_in,
  output logic tick_out
);

  logic level_d;

  // Delayed copy of the level; resets high so an input that is already high
  // when reset lifts is not mistaken for a rising edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b1;
    else        level_d <= level_in;
  end

  assign tick_out = level_in & ~level_d;

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road traffic light controller with pedestrian walk phase.
// Every state lasts an exact number of 1 ms ticks; a pedestrian request is
// served during the all-red gap following it, then the cycle resumes.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int T_GREEN  = 5000,
  parameter int T_YELLOW = 2000,
  parameter int T_ALLRED = 1000,
  parameter int T_WALK   = 4000
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic       clk_1KHz,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] state_o
);

  if (!t_ok(T_GREEN) || !t_ok(T_YELLOW) || !t_ok(T_ALLRED) || !t_ok(T_WALK)) begin : g_bad_timing
    $error("traffic_light_fsm: every duration parameter must be in 1..65535");
  end

  localparam logic [15:0] LAST_GREEN  = 16'(T_GREEN  - 1);
  localparam logic [15:0] LAST_YELLOW = 16'(T_YELLOW - 1);
  localparam logic [15:0] LAST_ALLRED = 16'(T_ALLRED - 1);
  localparam logic [15:0] LAST_WALK   = 16'(T_WALK   - 1);

  state_e      state_q, state_d;
  logic [15:0] tick_cnt;
  logic [15:0] last_cnt;
  logic        tick;
  logic        at_end;
  logic        ped_pending;
  logic        ret_ew;        // 1: walk returns to EW_GREEN, 0: to NS_GREEN
  logic        entering_walk;

  tick_edge_detect u_tick (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .level_in   (clk_1KHz),
    .tick_out   (tick)
  );

  // Final counter value of the current state.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    last_cnt = 16'd0;
    case (state_q)
      NS_GREEN,  EW_GREEN:  last_cnt = LAST_GREEN;
      NS_YELLOW, EW_YELLOW: last_cnt = LAST_YELLOW;
      ALLRED_1,  ALLRED_2:  last_cnt = LAST_ALLRED;
      PED_WALK:             last_cnt = LAST_WALK;
      default:              last_cnt = 16'd0;
    endcase
  end

  assign at_end = tick && (tick_cnt == last_cnt);

  // Next-state logic; an illegal code falls back to the safe all-red state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GREEN:  if (at_end) state_d = NS_YELLOW;
      NS_YELLOW: if (at_end) state_d = ALLRED_1;
      ALLRED_1:  if (at_end) state_d = ped_pending ? PED_WALK : EW_GREEN;
      EW_GREEN:  if (at_end) state_d = EW_YELLOW;
      EW_YELLOW: if (at_end) state_d = ALLRED_2;
      ALLRED_2:  if (at_end) state_d = ped_pending ? PED_WALK : NS_GREEN;
      PED_WALK:  if (at_end) state_d = ret_ew ? EW_GREEN : NS_GREEN;
      default:   state_d = ALLRED_2;
    endcase
  end

  assign entering_walk = (state_d == PED_WALK) && (state_q != PED_WALK);

  // State register and per-state tick counter.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ALLRED_2;
      tick_cnt <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) tick_cnt <= 16'd0;
      else if (tick)          tick_cnt <= tick_cnt + 16'd1;
    end
  end

  // Pedestrian latch and walk return direction; requests arriving while
  // entering or inside the walk phase are dropped.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      ped_pending <= 1'b0;
      ret_ew      <= 1'b0;
    end else if (entering_walk) begin
      ped_pending <= 1'b0;
      ret_ew      <= (state_q == ALLRED_1);
    end else if (ped_req && (state_q != PED_WALK)) begin
      ped_pending <= 1'b1;
    end
  end

  // Lamp decode straight from the state register.
  always_comb begin
    ns_light = RED;
    ew_light = RED;
    walk     = 1'b0;
    case (state_q)
      NS_GREEN:  ns_light = GRN;
      NS_YELLOW: ns_light = YEL;
      EW_GREEN:  ew_light = GRN;
      EW_YELLOW: ew_light = YEL;
      PED_WALK:  walk     = 1'b1;
      default:   ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with short durations and a 1 kHz
// stub whose period is 100 system clocks.
module tb_traffic_light_fsm;
  import traffic_pkg::*;

  localparam int TICK_CYC = 100;

  logic       clk_100MHz;
  logic       rst_n;
  logic       clk_1KHz;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit stub_run = 1'b1;
  int div      = 0;

  typedef struct {
    state_e     st;
    int         ticks;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } vec_t;

  vec_t vec [22];

  traffic_light_fsm #(
    .T_GREEN  (5),
    .T_YELLOW (2),
    .T_ALLRED (1),
    .T_WALK   (3)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .clk_1KHz   (clk_1KHz),
    .ped_req    (ped_req),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .walk       (walk),
    .state_o    (state_o)
  );

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  // 1 kHz stub: toggles every 50 system clocks, updated just after the edge.
  initial begin
    clk_1KHz = 1'b0;
    forever begin
      @(posedge clk_100MHz);
      #2;
      if (stub_run) begin
        if (div == 49) begin
          div      = 0;
          clk_1KHz = ~clk_1KHz;
        end else begin
          div++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Cycles spent in the current state, counted from its first observed cycle.
  task automatic hold_count(output int n);
    logic [2:0] s;
    s = state_o;
    n = 1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_100MHz);
      if (state_o != s) break;
      n++;
    end
  endtask

  task automatic wait_change(input int limit, output bit ok);
    logic [2:0] s;
    s  = state_o;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_100MHz);
      if (state_o != s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic goto_state(input state_e s, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_100MHz);
      if (state_o == s) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Waits for the stub to go low and then high again; returns on the
  // negedge where the new high level is first visible.
  task automatic wait_stub_rise(input string name);
    bit seen_low, ok;
    seen_low = 1'b0;
    ok       = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_100MHz);
      if (!clk_1KHz) seen_low = 1'b1;
      else if (seen_low) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    int n;
    for (int i = lo; i <= hi; i++) begin
      check($sformatf("vec%0d state", i), 32'(state_o), 32'(vec[i].st));
      check($sformatf("vec%0d ns", i),    32'(ns_light), 32'(vec[i].ns));
      check($sformatf("vec%0d ew", i),    32'(ew_light), 32'(vec[i].ew));
      check($sformatf("vec%0d walk", i),  32'(walk),     32'(vec[i].walk));
      hold_count(n);
      check($sformatf("vec%0d cycles", i), 32'(n), 32'(vec[i].ticks * TICK_CYC));
    end
  endtask

  initial begin
    bit ok;
    int bad;

    vec[0]  = '{NS_GREEN,  5, GRN, RED, 1'b0};
    vec[1]  = '{NS_YELLOW, 2, YEL, RED, 1'b0};
    vec[2]  = '{ALLRED_1,  1, RED, RED, 1'b0};
    vec[3]  = '{EW_GREEN,  5, RED, GRN, 1'b0};
    vec[4]  = '{EW_YELLOW, 2, RED, YEL, 1'b0};
    vec[5]  = '{ALLRED_2,  1, RED, RED, 1'b0};
    vec[6]  = '{NS_GREEN,  5, GRN, RED, 1'b0};
    vec[7]  = '{NS_YELLOW, 2, YEL, RED, 1'b0};
    vec[8]  = '{ALLRED_1,  1, RED, RED, 1'b0};
    vec[9]  = '{PED_WALK,  3, RED, RED, 1'b1};
    vec[10] = '{EW_GREEN,  5, RED, GRN, 1'b0};
    vec[11] = '{EW_YELLOW, 2, RED, YEL, 1'b0};
    vec[12] = '{ALLRED_2,  1, RED, RED, 1'b0};
    vec[13] = '{NS_GREEN,  5, GRN, RED, 1'b0};
    vec[14] = '{NS_YELLOW, 2, YEL, RED, 1'b0};
    vec[15] = '{ALLRED_1,  1, RED, RED, 1'b0};
    vec[16] = '{PED_WALK,  3, RED, RED, 1'b1};
    vec[17] = '{EW_GREEN,  5, RED, GRN, 1'b0};
    vec[18] = '{EW_YELLOW, 2, RED, YEL, 1'b0};
    vec[19] = '{ALLRED_2,  1, RED, RED, 1'b0};
    vec[20] = '{PED_WALK,  3, RED, RED, 1'b1};
    vec[21] = '{NS_GREEN,  5, GRN, RED, 1'b0};

    // Reset values.
    rst_n   = 1'b0;
    ped_req = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    check("rst state",   32'(state_o), 32'(ALLRED_2));
    check("rst ns",      32'(ns_light), 32'(RED));
    check("rst ew",      32'(ew_light), 32'(RED));
    check("rst walk",    32'(walk), 32'd0);
    check("rst cnt",     32'(dut.tick_cnt), 32'd0);
    check("rst pending", 32'(dut.ped_pending), 32'd0);
    check("rst ret",     32'(dut.ret_ew), 32'd0);

    // Plain cycle with no requests.
    rst_n = 1'b1;
    wait_change(300, ok);
    check("first exit", 32'(ok), 32'd1);
    run_vecs(0, 6);

    // Single-cycle request in NS_GREEN.
    goto_state(NS_GREEN, "goto ns_green ped");
    repeat (10) @(negedge clk_100MHz);
    ped_req = 1'b1;
    @(negedge clk_100MHz);
    ped_req = 1'b0;
    check("pulse pending set", 32'(dut.ped_pending), 32'd1);
    wait_change(1000, ok);
    check("pulse ns_green exit", 32'(ok), 32'd1);
    run_vecs(7, 9);
    check("pulse pending clear", 32'(dut.ped_pending), 32'd0);
    run_vecs(10, 13);

    // Request held high across two all-red gaps.
    ped_req = 1'b1;
    run_vecs(14, 16);
    check("held pending after walk", 32'(dut.ped_pending), 32'd0);
    run_vecs(17, 19);
    ped_req = 1'b0;
    run_vecs(20, 21);
    check("held pending end", 32'(dut.ped_pending), 32'd0);

    // Frozen 1 kHz input: nothing moves until the next genuine rising edge.
    goto_state(NS_GREEN, "goto ns_green freeze");
    stub_run = 1'b0;
    check("freeze level", 32'(clk_1KHz), 32'd1);
    check("freeze cnt0", 32'(dut.tick_cnt), 32'd0);
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk_100MHz);
      if (state_o != NS_GREEN || dut.tick_cnt != 16'd0) bad++;
    end
    check("freeze no change", 32'(bad), 32'd0);
    stub_run = 1'b1;
    wait_stub_rise("freeze resume rise");
    @(negedge clk_100MHz);
    check("freeze cnt step", 32'(dut.tick_cnt), 32'd1);
    check("freeze state", 32'(state_o), 32'(NS_GREEN));

    // Asynchronous reset in the middle of EW_GREEN with a request pending.
    goto_state(EW_GREEN, "goto ew_green");
    ped_req = 1'b1;
    @(negedge clk_100MHz);
    ped_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (dut.tick_cnt == 16'd3) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_100MHz);
    end
    check("reach cnt3", 32'(ok), 32'd1);
    check("mid pending", 32'(dut.ped_pending), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async state", 32'(state_o), 32'(ALLRED_2));
    check("async ns",    32'(ns_light), 32'(RED));
    check("async ew",    32'(ew_light), 32'(RED));
    check("async walk",  32'(walk), 32'd0);
    check("async pending", 32'(dut.ped_pending), 32'd0);
    check("async cnt",   32'(dut.tick_cnt), 32'd0);

    // Release reset while the 1 kHz input is already high.
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_100MHz);
      if (clk_1KHz) begin
        ok = 1'b1;
        break;
      end
    end
    check("high before release", 32'(ok), 32'd1);
    stub_run = 1'b0;
    @(negedge clk_100MHz);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_100MHz);
      if (state_o != ALLRED_2) bad++;
    end
    check("release no tick", 32'(bad), 32'd0);
    stub_run = 1'b1;
    wait_stub_rise("release resume rise");
    check("release before tick", 32'(state_o), 32'(ALLRED_2));
    @(negedge clk_100MHz);
    run_vecs(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
